mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage directly downstream of the ALU stage in the in-order integer/FP pipeline. It consumes the ALU stage's result together with the instruction's destination and class, and passes ALU results straight through to writeback. For `lw`/`flw`/`sw`/`fsw` it drives a valid/ready request port into data memory and waits for the load response. While a memory operation is outstanding it deasserts `n_stall` to hold the upstream stages.

## Interface
- `DMEM_AW`, default 16: data-memory word-address width; byte address bits `[DMEM_AW+1:2]` are used.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: an instruction is present from the ALU stage.
- `in_kind` in 2: instruction class.
  - 00: ALU result.
  - 01: load (`lw`/`flw`).
  - 10: store (`sw`/`fsw`).
  - 11: reserved.
- `in_addr` in 32: byte address for load/store.
- `in_data` in 32: ALU result (kind 00) or store data (kind 10).
- `in_rd` in 6: destination register; bit 5 = 1 selects the FP file.
- `n_stall` out 1: 1 = input accepted this cycle and upstream may advance; 0 = upstream holds.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_req_we` out 1: 1 = store.
- `mem_req_addr` out `DMEM_AW`: word address.
- `mem_req_wdata` out 32: store data.
- `mem_resp_valid` in 1, `mem_resp_rdata` in 32: load response.
- `wb_valid` out 1: one-cycle writeback strobe.
- `wb_rd` out 6: writeback destination.
- `wb_data` out 32: writeback data.
- `misalign` out 1: one-cycle pulse for a load/store with `in_addr[1:0]` ≠ 0.

## Operation
- FSM states: IDLE, REQ, WAIT.
- `n_stall` = (state == IDLE), combinational. Input is sampled only on edges where `n_stall` = 1 and `in_valid` = 1.
- **IDLE, kind 00:**
  - Next edge: `wb_valid` ← 1, `wb_rd` ← `in_rd`, `wb_data` ← `in_data`.
  - `wb_valid` is suppressed (0) when `in_rd` = 6'b000000 (integer x0). FP f0 (6'b100000) does write back.
- **IDLE, kind 11:** no effect; stay in IDLE.
- **IDLE, kind 01/10, `in_addr[1:0]` ≠ 0:**
  - `misalign` ← 1 for one cycle.
  - No request, no writeback; stay in IDLE.
- **IDLE, kind 01/10, aligned:**
  - Capture `mem_req_we` ← kind 10, `mem_req_addr` ← `in_addr[DMEM_AW+1:2]`, `mem_req_wdata` ← `in_data`, and a pending rd ← `in_rd`.
  - Go to REQ.
- **REQ:**
  - `mem_req_valid` = 1.
  - All `mem_req_*` fields are held stable until the handshake edge (valid && ready).
  - On handshake: store → IDLE; load → WAIT.
- **WAIT:**
  - On `mem_resp_valid` edge: `wb_valid` ← 1 (x0 suppression applies), `wb_rd` ← pending rd, `wb_data` ← `mem_resp_rdata`; go to IDLE.
- `mem_resp_valid` is ignored in IDLE and REQ. A response in the same cycle as the request handshake is not legal; memory responds at least one cycle after acceptance.
- `wb_valid` and `misalign` are single-cycle pulses. `wb_rd` and `wb_data` hold their last value when `wb_valid` = 0.
- `mem_req_valid` = (state == REQ), driven from the state register; no combinational path from `mem_req_ready`.

## Timing
- Reset values:
  - state = IDLE.
  - `wb_valid`, `wb_rd`, `wb_data`, `misalign`, `mem_req_we`, `mem_req_addr`, `mem_req_wdata`, pending rd = 0.
  - `mem_req_valid` = 0; `n_stall` = 1.
- Reset during REQ/WAIT:
  - Request is abandoned immediately (asynchronously); `mem_req_valid` falls without waiting for a clock.
  - A late response arriving after reset is ignored (state is IDLE).
  - No writeback is produced for the abandoned operation.
- ALU result latency: 1 cycle from accept edge to `wb_valid`. Back-to-back kind-00 instructions sustain one per cycle.
- Load:
  - Accept edge E0; `mem_req_valid` high from E0.
  - Handshake at edge E1 (earliest E0+1); response at edge E2 (earliest E1+1).
  - `wb_valid` high in the cycle after E2; `n_stall` = 1 in that same cycle.
  - Minimum occupancy: 3 cycles.
- Store: minimum occupancy 2 cycles; no writeback.
- `n_stall` is 0 for every cycle in REQ and WAIT. Upstream inputs are don't-care in those cycles.

## Test plan
- **Reset:** assert `rst` mid-cycle with no clock edge.
  - `mem_req_valid` = 0, `n_stall` = 1, `wb_valid` = 0 immediately.
- **ALU stream:** three kind-00 instructions on consecutive cycles: rd=5/`0x11`, rd=0/`0x22`, rd=6'h21/`0x33`.
  - `wb_valid` pattern 1,0,1 starting one cycle later.
  - `wb_data` `0x11`, then `0x33` to rd 6'h21.
  - `n_stall` stays 1 throughout.
- **Load, ready held low 3 cycles:** load addr `0x0000_0010`, rd=7; `mem_req_ready` held low for 3 cycles, response `0xDEADBEEF` two cycles after the handshake.
  - `mem_req_addr` = 4 and stable while waiting.
  - `n_stall` = 0 until the writeback cycle.
  - `wb_rd` = 7, `wb_data` = `0xDEADBEEF`.
- **Store, immediate ready:** store addr `0x0000_0008`, data `0xCAFEF00D`, `mem_req_ready` = 1.
  - One REQ cycle with `mem_req_we` = 1, `mem_req_addr` = 2, `mem_req_wdata` = `0xCAFEF00D`.
  - No `wb_valid`; IDLE again 2 cycles after accept.
- **Misaligned:** load at `0x0000_0006`.
  - `misalign` pulses one cycle; `mem_req_valid` never rises; no writeback.
- **Reset in WAIT:** assert `rst` while a load is in WAIT; release; then pulse `mem_resp_valid` with `0x1234`.
  - No `wb_valid` for the abandoned load.
  - The next kind-00 instruction completes normally.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results to writeback and runs one load/store
// at a time over a valid/ready request port, stalling upstream while it is busy.
module mem_stage #(
  parameter int DMEM_AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         in_kind,
  input  logic [31:0]        in_addr,
  input  logic [31:0]        in_data,
  input  logic [5:0]         in_rd,
  output logic               n_stall,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_we,
  output logic [DMEM_AW-1:0] mem_req_addr,
  output logic [31:0]        mem_req_wdata,
  input  logic               mem_resp_valid,
  input  logic [31:0]        mem_resp_rdata,
  output logic               wb_valid,
  output logic [5:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  localparam logic [1:0] KIND_ALU   = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_STORE = 2'b10;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [5:0]         prd_q, prd_d;
  logic               wb_valid_q, wb_valid_d;
  logic [5:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               misalign_q, misalign_d;

  // Only the word-address and byte-offset bits of in_addr matter here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^(in_addr >> (DMEM_AW + 2));

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    prd_d      = prd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_kind == KIND_ALU) begin
            // Integer x0 is never written; FP f0 (bit 5 set) is.
            if (in_rd != 6'd0) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = in_rd;
              wb_data_d  = in_data;
            end
          end else if (in_kind == KIND_LOAD || in_kind == KIND_STORE) begin
            if (in_addr[1:0] != 2'b00) begin
              misalign_d = 1'b1;
            end else begin
              we_d    = (in_kind == KIND_STORE);
              addr_d  = in_addr[DMEM_AW+1:2];
              wdata_d = in_data;
              prd_d   = in_rd;
              state_d = S_REQ;
            end
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = we_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (prd_q != 6'd0) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = prd_q;
            wb_data_d  = mem_resp_rdata;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      prd_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      prd_q      <= prd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  // Both decode straight from the state register, so reset drops them at once.
  assign n_stall       = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each task drives one scenario and compares
// outputs #1 after the rising edge against hand-computed values.
module tb_mem_stage;

  localparam int DMEM_AW = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [1:0]         in_kind = 2'b00;
  logic [31:0]        in_addr = '0;
  logic [31:0]        in_data = '0;
  logic [5:0]         in_rd = '0;
  logic               n_stall;
  logic               mem_req_valid;
  logic               mem_req_ready = 1'b0;
  logic               mem_req_we;
  logic [DMEM_AW-1:0] mem_req_addr;
  logic [31:0]        mem_req_wdata;
  logic               mem_resp_valid = 1'b0;
  logic [31:0]        mem_resp_rdata = '0;
  logic               wb_valid;
  logic [5:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               misalign;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_AW(DMEM_AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_kind        (in_kind),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_rd          (in_rd),
    .n_stall        (n_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misalign       (misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] d, input logic [5:0] rd);
    in_valid = v;
    in_kind  = k;
    in_addr  = a;
    in_data  = d;
    in_rd    = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL reset_n_stall got=%b exp=1", n_stall); end
    n_cmp++; if ({wb_valid, misalign, mem_req_we} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {wb_valid, misalign, mem_req_we}); end
    n_cmp++; if (wb_rd !== 6'd0 || wb_data !== 32'd0) begin n_bad++; $display("FAIL reset_wb got rd=%h data=%h exp 0/0", wb_rd, wb_data); end
    n_cmp++; if (mem_req_addr !== '0 || mem_req_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_req_fields got addr=%h wdata=%h exp 0/0", mem_req_addr, mem_req_wdata); end
    rst = 1'b0;
    // Enter REQ, then reset mid-cycle with no clock edge.
    mem_req_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_0040, 32'h0, 6'd2);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL pre_async_req_valid got=%b exp=1", mem_req_valid); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL async_req_valid got=%b exp=0", mem_req_valid); end
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL async_n_stall got=%b exp=1", n_stall); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL async_wb_valid got=%b exp=0", wb_valid); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_stream();
    drive(1'b1, 2'b00, 32'h0, 32'h11, 6'd5);
    tick();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 6'd5 || wb_data !== 32'h11) begin n_bad++; $display("FAIL alu0 got v=%b rd=%h d=%h exp 1/05/11", wb_valid, wb_rd, wb_data); end
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL alu0_n_stall got=%b exp=1", n_stall); end
    drive(1'b1, 2'b00, 32'h0, 32'h22, 6'd0);
    tick();
    n_cmp++; if (wb_valid !== 1'b0 || wb_rd !== 6'd5 || wb_data !== 32'h11) begin n_bad++; $display("FAIL alu_x0 got v=%b rd=%h d=%h exp 0/05/11", wb_valid, wb_rd, wb_data); end
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL alu1_n_stall got=%b exp=1", n_stall); end
    drive(1'b1, 2'b00, 32'h0, 32'h33, 6'h21);
    tick();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 6'h21 || wb_data !== 32'h33) begin n_bad++; $display("FAIL alu2 got v=%b rd=%h d=%h exp 1/21/33", wb_valid, wb_rd, wb_data); end
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL alu2_n_stall got=%b exp=1", n_stall); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL alu_end_wb_valid got=%b exp=0", wb_valid); end
  endtask

  task automatic test_load_backpressure();
    mem_req_ready = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_0010, 32'h0, 6'd7);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'd4 || mem_req_we !== 1'b0) begin n_bad++; $display("FAIL load_req[%0d] got v=%b addr=%h we=%b exp 1/0004/0", i, mem_req_valid, mem_req_addr, mem_req_we); end
      n_cmp++; if (n_stall !== 1'b0) begin n_bad++; $display("FAIL load_req_stall[%0d] got=%b exp=0", i, n_stall); end
      if (i < 2) tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b0 || n_stall !== 1'b0) begin n_bad++; $display("FAIL load_wait1 got v=%b ns=%b exp 0/0", mem_req_valid, n_stall); end
    tick();
    n_cmp++; if (n_stall !== 1'b0 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL load_wait2 got ns=%b wbv=%b exp 0/0", n_stall, wb_valid); end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 6'd7 || wb_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_wb got v=%b rd=%h d=%h exp 1/07/deadbeef", wb_valid, wb_rd, wb_data); end
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL load_wb_n_stall got=%b exp=1", n_stall); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL load_wb_pulse got=%b exp=0", wb_valid); end
  endtask

  task automatic test_store();
    mem_req_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_0008, 32'hCAFE_F00D, 6'd9);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 16'd2 || mem_req_wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL store_req got v=%b we=%b addr=%h wd=%h exp 1/1/0002/cafef00d", mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata); end
    n_cmp++; if (n_stall !== 1'b0 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL store_req_stall got ns=%b wbv=%b exp 0/0", n_stall, wb_valid); end
    tick();
    mem_req_ready = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b0 || n_stall !== 1'b1 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL store_done got v=%b ns=%b wbv=%b exp 0/1/0", mem_req_valid, n_stall, wb_valid); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL store_no_wb got=%b exp=0", wb_valid); end
  endtask

  task automatic test_misalign();
    mem_req_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h0000_0006, 32'h0, 6'd4);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    n_cmp++; if (misalign !== 1'b1 || mem_req_valid !== 1'b0 || n_stall !== 1'b1 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL misalign_pulse got ma=%b v=%b ns=%b wbv=%b exp 1/0/1/0", misalign, mem_req_valid, n_stall, wb_valid); end
    tick();
    n_cmp++; if (misalign !== 1'b0 || mem_req_valid !== 1'b0 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL misalign_after got ma=%b v=%b wbv=%b exp 0/0/0", misalign, mem_req_valid, wb_valid); end
    mem_req_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // FP f0 writes back; reserved kind does nothing and leaves wb fields alone.
    drive(1'b1, 2'b00, 32'h0, 32'h44, 6'h20);
    tick();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 6'h20 || wb_data !== 32'h44) begin n_bad++; $display("FAIL f0_wb got v=%b rd=%h d=%h exp 1/20/44", wb_valid, wb_rd, wb_data); end
    drive(1'b1, 2'b11, 32'h0000_0001, 32'h99, 6'd3);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    n_cmp++; if (wb_valid !== 1'b0 || misalign !== 1'b0 || mem_req_valid !== 1'b0 || n_stall !== 1'b1 || wb_data !== 32'h44) begin n_bad++; $display("FAIL reserved got wbv=%b ma=%b v=%b ns=%b d=%h exp 0/0/0/1/44", wb_valid, misalign, mem_req_valid, n_stall, wb_data); end
  endtask

  task automatic test_reset_in_wait();
    mem_req_ready = 1'b1;
    drive(1'b1, 2'b01, 32'h0000_0020, 32'h0, 6'd9);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    tick();
    mem_req_ready = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b0 || n_stall !== 1'b0) begin n_bad++; $display("FAIL rw_in_wait got v=%b ns=%b exp 0/0", mem_req_valid, n_stall); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (n_stall !== 1'b1) begin n_bad++; $display("FAIL rw_async_n_stall got=%b exp=1", n_stall); end
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_1234;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin n_bad++; $display("FAIL rw_late_resp got v=%b d=%h exp 0/00000000", wb_valid, wb_data); end
    drive(1'b1, 2'b00, 32'h0, 32'h55, 6'd3);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 6'd0);
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 6'd3 || wb_data !== 32'h55) begin n_bad++; $display("FAIL rw_next_alu got v=%b rd=%h d=%h exp 1/03/55", wb_valid, wb_rd, wb_data); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_stream();
    test_load_backpressure();
    test_store();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
